uart_imem_loader: RTL and testbench
===================================

Name: uart_imem_loader

Overview:
- UART receiver and loader that programs the instruction memory over its write port (WE/A/WD).
- Receives 8N1 serial bytes from a host, checks a framed load command, and assembles little-endian 32-bit words.
- Issues one single-cycle write per word to consecutive word addresses.
- Holds the core in reset (CORE_HOLD) while a load is in progress, then signals completion.

Parameters:
- CLKS_PER_BIT, 434, CLK cycles per UART bit (50 MHz / 115200); must be >= 4.
- MAX_WORDS, 20, instruction memory depth in words; largest accepted word count.
- SYNC_BYTE, 8'hA5, command byte that starts a load.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- RX  input  1  UART serial input, idle high, asynchronous to CLK.
- WE  output  1  instruction memory write enable; high for exactly one cycle per word.
- A  output  32  byte address of the write: {word_index, 2'b00}; upper bits zero.
- WD  output  32  write data, assembled little-endian (first byte received = WD[7:0]).
- CORE_HOLD  output  1  high while the core must be held in reset (load in progress or failed).
- DONE  output  1  sticky; high after a complete successful load.
- ERR  output  1  sticky; high after a framing error or an illegal word count.

Behaviour:
Reset (RST high, takes effect immediately):
- WE=0, A=0, WD=0, CORE_HOLD=0, DONE=0, ERR=0.
- RX front end and loader state machine return to their idle states.
- The core runs the preloaded image.

RX front end:
- RX passes through a 2-FF synchronizer; the synchronizer resets to 1.
- States: RX_IDLE, RX_START, RX_DATA, RX_STOP.
- RX_IDLE: a synchronized 0 moves to RX_START.
- RX_START: wait CLKS_PER_BIT/2 cycles, then sample. A 1 is a false start; return to RX_IDLE.
- RX_DATA: 8 samples spaced CLKS_PER_BIT apart, LSB first.
- RX_STOP: sample after a further CLKS_PER_BIT.
  - Stop bit 1: pulse byte_valid for 1 cycle with the byte.
  - Stop bit 0: pulse frame_err for 1 cycle.
  - Either way, return to RX_IDLE on the next cycle.

Loader FSM (states L_SYNC, L_COUNT, L_DATA, L_WRITE, L_DONE):
- L_SYNC:
  - Byte == SYNC_BYTE: CORE_HOLD=1, DONE=0, ERR=0, word_index=0, byte_index=0, go to L_COUNT.
  - Any other byte is ignored.
- L_COUNT:
  - Byte N with 1 <= N <= MAX_WORDS: latch N, go to L_DATA.
  - N=0 or N>MAX_WORDS: ERR=1, go to L_SYNC; CORE_HOLD stays 1.
- L_DATA:
  - Each byte is shifted into WD[8*byte_index +: 8] and byte_index increments.
  - On the 4th byte, go to L_WRITE.
- L_WRITE (one cycle):
  - WE=1, A={word_index,2'b00}, WD = the assembled word.
  - Next cycle: WE=0 and word_index increments.
  - If word_index+1 == N, go to L_DONE; otherwise go to L_DATA with byte_index=0.
- L_DONE (one cycle): CORE_HOLD=0, DONE=1, go to L_SYNC.

Write timing:
- WE rises exactly 1 cycle after the byte_valid of the 4th byte of each word.
- A and WD are stable from the cycle WE rises until the next write.
- A and WD hold their last values between writes.

Errors and aborts:
- frame_err in L_COUNT or L_DATA: ERR=1, discard the partial word (no WE), go to L_SYNC.
  - CORE_HOLD remains 1, because memory may be partially written.
- frame_err in L_SYNC: ERR=1, state unchanged.
- SYNC_BYTE received inside L_COUNT/L_DATA is treated as data; there is no mid-load restart.
- CORE_HOLD clears only on successful completion or reset.
- RST mid-load: immediate return to idle; CORE_HOLD=0 and no further writes.

Test Plan:
- CLKS_PER_BIT=16. Send A5, 01, 93, 00, 10, 00 -> one WE pulse with A=0, WD=32'h00100093. CORE_HOLD goes 1 after A5 and 0 with DONE=1 one cycle after the write.
- Send A5, 02, then 8 bytes for 32'h80000337 and 32'h00000013 -> two WE pulses at A=0 and A=4 with those values, in order. DONE=1.
- Send A5, 00 -> ERR=1, no WE, CORE_HOLD=1. A following valid load (A5, 01, 4 bytes) -> ERR=0, DONE=1, CORE_HOLD=0.
- Send A5, 15 (21 words) -> ERR=1, no WE.
- Send A5, 01, 13, 00, then a byte with stop bit 0 -> ERR=1, no WE, FSM in L_SYNC, CORE_HOLD=1.
- Glitch RX low for 3 cycles while idle -> false start, no byte_valid. Assert RST during the 3rd data byte -> all outputs 0 at once, no WE afterwards.

Source files
------------

// File: rtl/uart_imem_loader.sv
// UART 8N1 receiver feeding a framed loader that writes little-endian 32-bit words
// into the instruction memory, holding the core in reset while a load is in flight.
module uart_imem_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         MAX_WORDS    = 20,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RX,
    output logic        WE,
    output logic [31:0] A,
    output logic [31:0] WD,
    output logic        CORE_HOLD,
    output logic        DONE,
    output logic        ERR
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {L_SYNC, L_COUNT, L_DATA, L_WRITE, L_DONE} ld_state_e;

    logic             rx_meta_q, rx_sync_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    ld_state_e        ld_state_q, ld_state_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [IDX_W-1:0] word_idx_inc;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      asm_q, asm_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      wd_q, wd_d;
    logic             hold_q, hold_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             count_ok;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                    else               bit_d      = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d        = '0;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                    rx_state_d   = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign word_idx_inc = word_idx_q + IDX_W'(1);
    assign count_ok     = (shift_q != 8'd0) && (int'(shift_q) <= MAX_WORDS);

    always_comb begin
        ld_state_d = ld_state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        a_d        = a_q;
        wd_d       = wd_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;
        case (ld_state_q)
            L_SYNC: begin
                if (byte_valid_q && shift_q == SYNC_BYTE) begin
                    hold_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    ld_state_d = L_COUNT;
                end else if (frame_err_q) begin
                    err_d = 1'b1;
                end
            end
            L_COUNT: begin
                if (frame_err_q || (byte_valid_q && !count_ok)) begin
                    err_d      = 1'b1;
                    ld_state_d = L_SYNC;
                end else if (byte_valid_q) begin
                    n_d        = shift_q[IDX_W-1:0];
                    ld_state_d = L_DATA;
                end
            end
            L_DATA: begin
                if (frame_err_q) begin
                    err_d      = 1'b1;
                    ld_state_d = L_SYNC;
                end else if (byte_valid_q) begin
                    asm_d[8*byte_idx_q +: 8] = shift_q;
                    byte_idx_d               = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Outputs only change here, so A/WD hold steady between writes.
                        a_d        = {{(30-IDX_W){1'b0}}, word_idx_q, 2'b00};
                        wd_d       = {shift_q, asm_q[23:0]};
                        ld_state_d = L_WRITE;
                    end
                end
            end
            L_WRITE: begin
                word_idx_d = word_idx_inc;
                if (word_idx_inc == n_q) begin
                    hold_d     = 1'b0;
                    done_d     = 1'b1;
                    ld_state_d = L_DONE;
                end else begin
                    byte_idx_d = '0;
                    ld_state_d = L_DATA;
                end
            end
            L_DONE:  ld_state_d = L_SYNC;
            default: ld_state_d = L_SYNC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ld_state_q   <= L_SYNC;
            n_q          <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            a_q          <= '0;
            wd_q         <= '0;
            hold_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rx_meta_q    <= RX;
            rx_sync_q    <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            ld_state_q   <= ld_state_d;
            n_q          <= n_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            a_q          <= a_d;
            wd_q         <= wd_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign WE        = (ld_state_q == L_WRITE);
    assign A         = a_q;
    assign WD        = wd_q;
    assign CORE_HOLD = hold_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: serial loads, count bounds, framing errors,
// false starts and mid-load reset, with writes captured by a WE monitor.
module tb_uart_imem_loader;

    localparam int CPB = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RX  = 1'b1;
    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic        CORE_HOLD;
    logic        DONE;
    logic        ERR;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  hd_at;     // {CORE_HOLD, DONE} in the WE cycle
        logic [1:0]  hd_after;  // {CORE_HOLD, DONE} one cycle later
    } wr_t;

    wr_t wr_log[$];
    wr_t mon_w;

    uart_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .MAX_WORDS   (20),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX       (RX),
        .WE       (WE),
        .A        (A),
        .WD       (WD),
        .CORE_HOLD(CORE_HOLD),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    always begin
        @(negedge CLK);
        if (WE === 1'b1) begin
            mon_w.a     = A;
            mon_w.wd    = WD;
            mon_w.hd_at = {CORE_HOLD, DONE};
            @(negedge CLK);
            mon_w.hd_after = {CORE_HOLD, DONE};
            wr_log.push_back(mon_w);
        end
    end

    task automatic drive_bit(input logic v);
        RX = v;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge CLK);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        RX = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * CPB) @(negedge CLK);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        RX  = 1'b1;
        repeat (3) @(negedge CLK);
        total_cnt++;
        if ({WE, A, WD, CORE_HOLD, DONE, ERR} !== 68'd0)
            $display("FAIL reset_outputs: WE=%b A=%h WD=%h HOLD=%b DONE=%b ERR=%b, want all 0", WE, A, WD, CORE_HOLD, DONE, ERR);
        else pass_cnt++;
        RST = 1'b0;
        idle_bits(1);
        total_cnt++;
        if ({WE, CORE_HOLD, DONE, ERR} !== 4'd0)
            $display("FAIL idle_after_reset: WE/HOLD/DONE/ERR=%b, want 0000", {WE, CORE_HOLD, DONE, ERR});
        else pass_cnt++;
    endtask

    task automatic test_single_word;
        wr_log.delete();
        send_byte(8'hA5, 1'b1);
        total_cnt++;
        if ({CORE_HOLD, DONE, ERR} !== 3'b100)
            $display("FAIL single_hold_after_sync: HOLD/DONE/ERR=%b, want 100", {CORE_HOLD, DONE, ERR});
        else pass_cnt++;
        send_byte(8'h01, 1'b1);
        send_word(32'h00100093);
        idle_bits(2);
        total_cnt++;
        if (wr_log.size() !== 1)
            $display("FAIL single_we_count: got %0d writes, want 1", wr_log.size());
        else pass_cnt++;
        if (wr_log.size() == 1) begin
            total_cnt++;
            if (wr_log[0].a !== 32'd0 || wr_log[0].wd !== 32'h00100093)
                $display("FAIL single_write: A=%h WD=%h, want A=00000000 WD=00100093", wr_log[0].a, wr_log[0].wd);
            else pass_cnt++;
            total_cnt++;
            if (wr_log[0].hd_at !== 2'b10 || wr_log[0].hd_after !== 2'b01)
                $display("FAIL single_done_timing: HOLD/DONE at WE=%b next=%b, want 10 then 01", wr_log[0].hd_at, wr_log[0].hd_after);
            else pass_cnt++;
        end
        total_cnt++;
        if ({CORE_HOLD, DONE, ERR} !== 3'b010)
            $display("FAIL single_final: HOLD/DONE/ERR=%b, want 010", {CORE_HOLD, DONE, ERR});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        wr_log.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_word(32'h80000337);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        total_cnt++;
        if (wr_log.size() !== 1 || A !== 32'd0 || WD !== 32'h80000337)
            $display("FAIL b2b_hold_between: writes=%0d A=%h WD=%h, want 1 00000000 80000337", wr_log.size(), A, WD);
        else pass_cnt++;
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        idle_bits(2);
        total_cnt++;
        if (wr_log.size() !== 2)
            $display("FAIL b2b_we_count: got %0d writes, want 2", wr_log.size());
        else pass_cnt++;
        if (wr_log.size() == 2) begin
            total_cnt++;
            if (wr_log[0].a !== 32'd0 || wr_log[0].wd !== 32'h80000337 || wr_log[0].hd_after !== 2'b10)
                $display("FAIL b2b_first: A=%h WD=%h HD_after=%b, want 00000000 80000337 10", wr_log[0].a, wr_log[0].wd, wr_log[0].hd_after);
            else pass_cnt++;
            total_cnt++;
            if (wr_log[1].a !== 32'd4 || wr_log[1].wd !== 32'h00000013 || wr_log[1].hd_after !== 2'b01)
                $display("FAIL b2b_second: A=%h WD=%h HD_after=%b, want 00000004 00000013 01", wr_log[1].a, wr_log[1].wd, wr_log[1].hd_after);
            else pass_cnt++;
        end
        total_cnt++;
        if ({CORE_HOLD, DONE, ERR} !== 3'b010 || A !== 32'd4 || WD !== 32'h00000013)
            $display("FAIL b2b_final: HOLD/DONE/ERR=%b A=%h WD=%h, want 010 00000004 00000013", {CORE_HOLD, DONE, ERR}, A, WD);
        else pass_cnt++;
    endtask

    task automatic test_zero_count;
        wr_log.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        idle_bits(1);
        total_cnt++;
        if ({CORE_HOLD, DONE, ERR} !== 3'b101 || wr_log.size() !== 0)
            $display("FAIL zero_count: HOLD/DONE/ERR=%b writes=%0d, want 101 0", {CORE_HOLD, DONE, ERR}, wr_log.size());
        else pass_cnt++;
        send_byte(8'hA5, 1'b1);
        total_cnt++;
        if ({CORE_HOLD, DONE, ERR} !== 3'b100)
            $display("FAIL zero_resync: HOLD/DONE/ERR=%b, want 100", {CORE_HOLD, DONE, ERR});
        else pass_cnt++;
        send_byte(8'h01, 1'b1);
        send_word(32'h00000013);
        idle_bits(2);
        total_cnt++;
        if ({CORE_HOLD, DONE, ERR} !== 3'b010 || wr_log.size() !== 1)
            $display("FAIL zero_recover: HOLD/DONE/ERR=%b writes=%0d, want 010 1", {CORE_HOLD, DONE, ERR}, wr_log.size());
        else pass_cnt++;
        if (wr_log.size() == 1) begin
            total_cnt++;
            if (wr_log[0].a !== 32'd0 || wr_log[0].wd !== 32'h00000013)
                $display("FAIL zero_recover_write: A=%h WD=%h, want 00000000 00000013", wr_log[0].a, wr_log[0].wd);
            else pass_cnt++;
        end
    endtask

    task automatic test_count_bounds;
        wr_log.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h15, 1'b1);
        idle_bits(1);
        total_cnt++;
        if ({CORE_HOLD, DONE, ERR} !== 3'b101 || wr_log.size() !== 0)
            $display("FAIL count_21: HOLD/DONE/ERR=%b writes=%0d, want 101 0", {CORE_HOLD, DONE, ERR}, wr_log.size());
        else pass_cnt++;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h14, 1'b1);
        idle_bits(1);
        total_cnt++;
        if ({CORE_HOLD, DONE, ERR} !== 3'b100)
            $display("FAIL count_20_accepted: HOLD/DONE/ERR=%b, want 100", {CORE_HOLD, DONE, ERR});
        else pass_cnt++;
        send_byte(8'h37, 1'b0);
        idle_bits(12);
        total_cnt++;
        if ({CORE_HOLD, DONE, ERR} !== 3'b101 || wr_log.size() !== 0)
            $display("FAIL count_20_abort: HOLD/DONE/ERR=%b writes=%0d, want 101 0", {CORE_HOLD, DONE, ERR}, wr_log.size());
        else pass_cnt++;
    endtask

    task automatic test_frame_error;
        wr_log.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h55, 1'b0);
        idle_bits(12);
        total_cnt++;
        if ({CORE_HOLD, DONE, ERR} !== 3'b101 || wr_log.size() !== 0)
            $display("FAIL frame_err_data: HOLD/DONE/ERR=%b writes=%0d, want 101 0", {CORE_HOLD, DONE, ERR}, wr_log.size());
        else pass_cnt++;
        send_word(32'h00000013);
        idle_bits(2);
        total_cnt++;
        if ({CORE_HOLD, DONE, ERR} !== 3'b101 || wr_log.size() !== 0)
            $display("FAIL frame_err_back_in_sync: HOLD/DONE/ERR=%b writes=%0d, want 101 0", {CORE_HOLD, DONE, ERR}, wr_log.size());
        else pass_cnt++;
    endtask

    task automatic test_glitch_and_reset;
        wr_log.delete();
        send_byte(8'hA5, 1'b1);
        @(negedge CLK);
        RX = 1'b0;
        repeat (3) @(negedge CLK);
        RX = 1'b1;
        idle_bits(2);
        send_byte(8'h01, 1'b1);
        @(negedge CLK);
        RX = 1'b0;
        repeat (3) @(negedge CLK);
        RX = 1'b1;
        idle_bits(2);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        total_cnt++;
        if ({CORE_HOLD, DONE, ERR} !== 3'b100 || wr_log.size() !== 0)
            $display("FAIL glitch_ignored: HOLD/DONE/ERR=%b writes=%0d, want 100 0", {CORE_HOLD, DONE, ERR}, wr_log.size());
        else pass_cnt++;
        @(negedge CLK);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        #2 RST = 1'b1;
        #1;
        total_cnt++;
        if ({WE, A, WD, CORE_HOLD, DONE, ERR} !== 68'd0)
            $display("FAIL async_reset: WE=%b A=%h WD=%h HOLD=%b DONE=%b ERR=%b, want all 0", WE, A, WD, CORE_HOLD, DONE, ERR);
        else pass_cnt++;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 6; i++) drive_bit(1'b1);
        drive_bit(1'b1);
        idle_bits(12);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        idle_bits(2);
        total_cnt++;
        if ({WE, CORE_HOLD, DONE, ERR} !== 4'd0 || wr_log.size() !== 0)
            $display("FAIL post_reset_quiet: WE/HOLD/DONE/ERR=%b writes=%0d, want 0000 0", {WE, CORE_HOLD, DONE, ERR}, wr_log.size());
        else pass_cnt++;
        send_byte(8'h00, 1'b0);
        idle_bits(12);
        total_cnt++;
        if ({CORE_HOLD, DONE, ERR} !== 3'b001)
            $display("FAIL frame_err_sync: HOLD/DONE/ERR=%b, want 001", {CORE_HOLD, DONE, ERR});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_zero_count();
        test_count_bounds();
        test_frame_error();
        test_glitch_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
